// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle execute-stage ALU: function codes, FSM states
// and the helpers that classify function codes.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    ALU_ZERO      = 5'd0,
    ALU_ADD       = 5'd1,
    ALU_SUB       = 5'd2,
    ALU_XOR       = 5'd3,
    ALU_OR        = 5'd4,
    ALU_AND       = 5'd5,
    ALU_A         = 5'd6,
    ALU_B         = 5'd7,
    ALU_ADD_CLEAR = 5'd8,
    ALU_SLL       = 5'd9,
    ALU_SRL       = 5'd10,
    ALU_SRA       = 5'd11,
    ALU_SLT       = 5'd12,
    ALU_SLTU      = 5'd13,
    ALU_MUL       = 5'd14,
    ALU_DIV       = 5'd15,
    ALU_DIVU      = 5'd16,
    ALU_REM       = 5'd17,
    ALU_REMU      = 5'd18
  } alufunc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mc_state_t;

  function automatic logic is_mul(alufunc_t f);
    return f == ALU_MUL;
  endfunction

  function automatic logic is_div(alufunc_t f);
    return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result bundle between the issue register, the ALU and the
// execute/memory pipeline register.
interface alu_mc_if #(parameter int WIDTH = 64);
  import alu_mc_pkg::*;

  // in_valid/in_ready: an op transfers on a cycle where both are high and flush
  // is low; out_valid/out_ready: c transfers when both are high, and c and
  // out_valid stay stable while out_valid && !out_ready. flush beats both.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alufunc_t         alufunc;
  logic             word;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;

  modport master (
    output in_valid, a, b, alufunc, word, flush, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, alufunc, word, flush, out_ready,
    output in_ready, out_valid, c
  );

endinterface

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// done is high during the cycle whose closing edge performs the last iteration.
module muldiv_iter
  import alu_mc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  alufunc_t         func,
    input  logic             word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q, mul_q, rem_q, word_q, neg_quo_q, neg_rem_q, dz_q;
  logic [CW-1:0]    cnt_q, n_iter;
  logic [WIDTH-1:0] hi_q, lo_q, op_q;
  logic [WIDTH:0]   rem_sh;
  logic             ge, sgn, a_neg, b_neg;
  logic [WIDTH-1:0] da, db, ma, mb, quo, rmd, raw;

  always_comb begin
    sgn   = func inside {ALU_DIV, ALU_REM};
    da    = word ? (sgn ? WIDTH'($signed(a[31:0])) : WIDTH'(a[31:0])) : a;
    db    = word ? (sgn ? WIDTH'($signed(b[31:0])) : WIDTH'(b[31:0])) : b;
    a_neg = sgn && da[WIDTH-1];
    b_neg = sgn && db[WIDTH-1];
    ma    = a_neg ? -da : da;
    mb    = b_neg ? -db : db;
  end

  assign n_iter = word_q ? CW'(32) : CW'(WIDTH);
  assign done   = busy_q && (cnt_q == n_iter - CW'(1));
  assign rem_sh = {hi_q, lo_q[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, op_q};

  // hi = accumulator / partial remainder, lo = multiplier / dividend->quotient,
  // op = shifting multiplicand / divisor magnitude.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mul_q     <= 1'b0;
      rem_q     <= 1'b0;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_q      <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q    <= 1'b1;
      cnt_q     <= '0;
      mul_q     <= (func == ALU_MUL);
      rem_q     <= func inside {ALU_REM, ALU_REMU};
      word_q    <= word;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= (db == '0);
      hi_q      <= '0;
      if (func == ALU_MUL) begin
        lo_q <= db;
        op_q <= da;
      end else begin
        // W-mode dividend is pre-aligned so its MSB leaves lo first
        lo_q <= word ? (ma << 32) : ma;
        op_q <= mb;
      end
    end else if (busy_q) begin
      busy_q <= !done;
      cnt_q  <= done ? '0 : cnt_q + CW'(1);
      if (mul_q) begin
        hi_q <= hi_q + (lo_q[0] ? op_q : '0);
        op_q <= op_q << 1;
        lo_q <= lo_q >> 1;
      end else begin
        hi_q <= ge ? WIDTH'(rem_sh - {1'b0, op_q}) : rem_sh[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], ge};
      end
    end
  end

  always_comb begin
    quo    = dz_q ? '1 : (neg_quo_q ? -lo_q : lo_q);
    rmd    = neg_rem_q ? -hi_q : hi_q;
    raw    = mul_q ? hi_q : (rem_q ? rmd : quo);
    result = word_q ? WIDTH'($signed(raw[31:0])) : raw;
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked execute-stage ALU: single-cycle ops straight into the output
// register, MUL/DIV/REM through the iterative core.
module alu_mc
  import alu_mc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic      clk,
    input  logic      resetn,
    alu_mc_if.slave   bus,
    output mc_state_t dbg_state
);
  localparam int SW = $clog2(WIDTH);

  mc_state_t        state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q, c_d, single_res, md_result, sa, sb, za, r;
  logic [SW-1:0]    shamt;
  logic             word_eff, out_free, accept, md_start, md_done;

  assign word_eff = bus.word && (WIDTH > 32);

  // W-mode works on sign-extended operands; only SRL needs the zero-extended view.
  always_comb begin
    sa    = word_eff ? WIDTH'($signed(bus.a[31:0])) : bus.a;
    sb    = word_eff ? WIDTH'($signed(bus.b[31:0])) : bus.b;
    za    = word_eff ? WIDTH'(bus.a[31:0]) : bus.a;
    shamt = word_eff ? SW'(bus.b[4:0]) : bus.b[SW-1:0];
    r     = '0;
    case (bus.alufunc)
      ALU_ADD:       r = sa + sb;
      ALU_SUB:       r = sa - sb;
      ALU_XOR:       r = sa ^ sb;
      ALU_OR:        r = sa | sb;
      ALU_AND:       r = sa & sb;
      ALU_A:         r = sa;
      ALU_B:         r = sb;
      ALU_ADD_CLEAR: r = (sa + sb) & {{(WIDTH-1){1'b1}}, 1'b0};
      ALU_SLL:       r = sa << shamt;
      ALU_SRL:       r = za >> shamt;
      ALU_SRA:       r = WIDTH'($signed(sa) >>> shamt);
      ALU_SLT:       r = WIDTH'($signed(sa) < $signed(sb));
      ALU_SLTU:      r = WIDTH'(sa < sb);
      default:       r = '0;
    endcase
    single_res = word_eff ? WIDTH'($signed(r[31:0])) : r;
  end

  assign out_free     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = resetn && (state_q == IDLE) && out_free;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign md_start     = accept && (is_mul(bus.alufunc) || is_div(bus.alufunc));

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .resetn (resetn),
    .start  (md_start),
    .abort  (bus.flush),
    .func   (bus.alufunc),
    .word   (word_eff),
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    c_d         = c_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul(bus.alufunc)) begin
            state_d = MUL;
          end else if (is_div(bus.alufunc)) begin
            state_d = DIV;
          end else begin
            c_d         = single_res;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL, DIV: if (md_done) state_d = DONE;
      DONE: begin
        if (out_free) begin
          c_d         = md_result;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=64: single-cycle ops, W-mode, MUL/DIV
// latency and corner cases, back-pressure, flush and mid-operation reset.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 64;

  logic      clk = 1'b0;
  logic      resetn;
  mc_state_t dbg_state;
  int        n_checks = 0;
  int        n_pass   = 0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alufunc   = ALU_ZERO;
    bus.word      = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic set_op(input alufunc_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic wd);
    bus.in_valid = 1'b1;
    bus.alufunc  = f;
    bus.a        = a;
    bus.b        = b;
    bus.word     = wd;
  endtask

  // Issues one MUL/DIV op, then counts edges until out_valid; lat = -1 on timeout.
  task automatic md_op(input alufunc_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic wd, output int lat, output logic [W-1:0] res,
                       output bit ir_low);
    set_op(f, a, b, wd);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat    = -1;
    res    = 'x;
    ir_low = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      if (bus.in_ready !== 1'b0) ir_low = 1'b0;
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        res = bus.c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.c !== '0) $display("FAIL reset_c: got %h want 0", bus.c);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    else n_pass++;
    resetn = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    alufunc_t ops [14] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SRA, ALU_ADD_CLEAR, ALU_SLT,
                           ALU_SLTU, ALU_SLL, ALU_SRL, ALU_OR, ALU_AND, ALU_A, ALU_B,
                           alufunc_t'(5'd31)};
    logic [W-1:0] av [14] = '{64'd5, 64'd5, 64'hF0, 64'h8000_0000_0000_0000, 64'd3,
                              '1, '1, 64'd1, 64'h8000_0000_0000_0000, 64'hF0, 64'hF0,
                              64'd9, 64'd9, 64'd3};
    logic [W-1:0] bv [14] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFF,
                              64'd4, 64'd4, 64'd1, 64'd1, 64'd65, 64'd63, 64'h0F, 64'h3C,
                              64'd4, 64'd4, 64'd4};
    logic [W-1:0] ev [14] = '{64'd2, 64'd8, 64'h0F, 64'hF800_0000_0000_0000, 64'd6,
                              64'd1, 64'd0, 64'd2, 64'd1, 64'hFF, 64'h30, 64'd9, 64'd4,
                              64'd0};
    for (int i = 0; i < 14; i++) begin
      set_op(ops[i], av[i], bv[i], 1'b0);
      n_checks++;
      if (bus.in_ready !== 1'b1)
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== ev[i])
        $display("FAIL b2b_result[%0d]: got valid=%b c=%h want valid=1 c=%h",
                 i, bus.out_valid, bus.c, ev[i]);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain: got valid=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_word_mode();
    alufunc_t ops [6] = '{ALU_ADD, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SUB, ALU_SLTU};
    logic [W-1:0] av [6] = '{64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000,
                             64'hFFFF_FFFF_8000_0000, 64'd0, 64'h1_0000_0000};
    logic [W-1:0] bv [6] = '{64'd1, 64'd33, 64'd4, 64'd4, 64'd1, 64'd1};
    logic [W-1:0] ev [6] = '{64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_0800_0000,
                             64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    for (int i = 0; i < 6; i++) begin
      set_op(ops[i], av[i], bv[i], 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== ev[i])
        $display("FAIL word_result[%0d]: got valid=%b c=%h want valid=1 c=%h",
                 i, bus.out_valid, bus.c, ev[i]);
      else n_pass++;
    end
    drive_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int           lat;
    logic [W-1:0] res;
    bit           ir_low;
    md_op(ALU_MUL, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b0, lat, res, ir_low);
    n_checks++;
    if (lat !== 65) $display("FAIL mul_latency: got %0d want 65", lat);
    else n_pass++;
    n_checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFD6) $display("FAIL mul_result: got %h want %h", res,
                                                  64'hFFFF_FFFF_FFFF_FFD6);
    else n_pass++;
    n_checks++;
    if (ir_low !== 1'b1) $display("FAIL mul_in_ready_low: got %b want 1", ir_low);
    else n_pass++;
    md_op(ALU_MUL, 64'hDEAD_0000_7FFF_FFFF, 64'd2, 1'b1, lat, res, ir_low);
    n_checks++;
    if (lat !== 33) $display("FAIL mulw_latency: got %0d want 33", lat);
    else n_pass++;
    n_checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mulw_result: got %h want %h", res,
                                                  64'hFFFF_FFFF_FFFF_FFFE);
    else n_pass++;
  endtask

  task automatic test_div();
    alufunc_t ops [9] = '{ALU_DIV, ALU_REMU, ALU_DIV, ALU_REM, ALU_DIV, ALU_REM, ALU_DIVU,
                          ALU_REMU, ALU_DIV};
    logic [W-1:0] av [9] = '{64'd7, 64'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                             64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100,
                             64'd100, 64'h0000_0000_FFFF_FFF9};
    logic [W-1:0] bv [9] = '{64'd0, 64'd0, '1, '1, 64'd2, 64'd2, 64'd7, 64'd7, 64'd2};
    logic [W-1:0] ev [9] = '{'1, 64'd7, 64'h8000_0000_0000_0000, 64'd0,
                             64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd14, 64'd2,
                             64'hFFFF_FFFF_FFFF_FFFD};
    logic         wv [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int           lv [9] = '{65, 65, 65, 65, 65, 65, 65, 65, 33};
    int           lat;
    logic [W-1:0] res;
    bit           ir_low;
    for (int i = 0; i < 9; i++) begin
      md_op(ops[i], av[i], bv[i], wv[i], lat, res, ir_low);
      n_checks++;
      if (res !== ev[i] || lat !== lv[i])
        $display("FAIL div_case[%0d]: got c=%h lat=%0d want c=%h lat=%0d",
                 i, res, lat, ev[i], lv[i]);
      else n_pass++;
    end
    drive_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    set_op(ALU_ADD, 64'd1, 64'd2, 1'b0);
    @(posedge clk); #1;
    set_op(ALU_SUB, 64'd10, 64'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== 64'd3 || bus.in_ready !== 1'b0)
        $display("FAIL stall[%0d]: got valid=%b c=%h in_ready=%b want valid=1 c=3 in_ready=0",
                 i, bus.out_valid, bus.c, bus.in_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.c !== 64'd6)
      $display("FAIL release_next: got valid=%b c=%h want valid=1 c=6", bus.out_valid, bus.c);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int spurious;
    bus.out_ready = 1'b0;
    set_op(ALU_ADD, 64'd1, 64'd1, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    set_op(ALU_ADD, 64'd5, 64'd5, 1'b0);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_priority: got valid=%b want 0", bus.out_valid);
    else n_pass++;
    set_op(ALU_DIV, 64'd100, 64'd7, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (dbg_state !== DIV) $display("FAIL flush_pre_state: got %0d want DIV", dbg_state);
    else n_pass++;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++;
    if (dbg_state !== IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_div: got state=%0d valid=%b in_ready=%b want IDLE/0/1",
               dbg_state, bus.out_valid, bus.in_ready);
    else n_pass++;
    set_op(ALU_ADD, 64'd20, 64'd22, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.c !== 64'd42)
      $display("FAIL flush_next_add: got valid=%b c=%h want valid=1 c=42", bus.out_valid, bus.c);
    else n_pass++;
    @(posedge clk); #1;
    spurious = 0;
    for (int k = 0; k < 80; k++) begin
      if (bus.out_valid !== 1'b0) spurious++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (spurious !== 0) $display("FAIL flush_no_output: got %0d valid cycles want 0", spurious);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    set_op(ALU_MUL, 64'd3, 64'd4, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL reset_mid_mul: got state=%0d valid=%b in_ready=%b want IDLE/0/0",
               dbg_state, bus.out_valid, bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    resetn = 1'b1;
    set_op(ALU_ADD, 64'd1, 64'd1, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.c !== 64'd2)
      $display("FAIL reset_next_add: got valid=%b c=%h want valid=1 c=2", bus.out_valid, bus.c);
    else n_pass++;
    @(posedge clk); #1;
    spurious = 0;
    for (int k = 0; k < 80; k++) begin
      if (bus.out_valid !== 1'b0) spurious++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (spurious !== 0) $display("FAIL reset_no_output: got %0d valid cycles want 0", spurious);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_word_mode();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
